// File: rtl/sram_array_rd_frontend.sv
// Valid/ready read front-end for a 1R1W array macro with 1-cycle read latency.
// Writes pass straight through; reads return in order through a 2-entry buffer with bypass.
module sram_array_rd_frontend #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              sram_r_en,
  output logic [ADDR_W-1:0] sram_r_addr,
  input  logic [DATA_W-1:0] sram_r_data,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_w_addr,
  output logic [DATA_W-1:0] sram_w_data
);

  logic              inflight_q;
  logic [1:0]        buf_count_q, buf_count_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [DATA_W-1:0] buf_q [2];
  logic              byp_hit_q, byp_hit_d;
  logic [DATA_W-1:0] byp_data_q;

  logic              fire;
  logic [1:0]        occ;
  logic [DATA_W-1:0] rd_data;
  logic              pop;
  logic              head_pop;
  logic              push;

  assign sram_w_en   = wr_valid;
  assign sram_w_addr = wr_addr;
  assign sram_w_data = wr_data;

  // Credit depends on registered state only, so req_ready has no input-to-output path.
  assign occ       = buf_count_q + {1'b0, inflight_q};
  assign req_ready = (occ < 2'd2);
  assign fire      = req_valid && req_ready;

  assign sram_r_en   = fire;
  assign sram_r_addr = fire ? req_addr : '0;

  // A write to the same address in the request cycle wins over the macro's read data.
  assign rd_data = byp_hit_q ? byp_data_q : sram_r_data;

  always_comb begin
    resp_valid = (buf_count_q != 2'd0) || inflight_q;
    resp_data  = '0;
    if (buf_count_q != 2'd0) begin
      resp_data = buf_q[head_q];
    end else if (inflight_q) begin
      resp_data = rd_data;
    end
  end

  assign pop      = resp_valid && resp_ready;
  assign head_pop = pop && (buf_count_q != 2'd0);
  // Returning data is consumed directly only when it was on the bypass path and popped.
  assign push     = inflight_q && !((buf_count_q == 2'd0) && resp_ready);

  always_comb begin
    buf_count_d = buf_count_q + {1'b0, push} - {1'b0, head_pop};
    head_d      = head_pop ? ~head_q : head_q;
    tail_d      = push ? ~tail_q : tail_q;
    byp_hit_d   = fire && wr_valid && (wr_addr == req_addr);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q  <= 1'b0;
      buf_count_q <= 2'd0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      byp_hit_q   <= 1'b0;
    end else begin
      inflight_q  <= fire;
      buf_count_q <= buf_count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      byp_hit_q   <= byp_hit_d;
    end
  end

  // Data storage carries no reset; validity is tracked by the control state above.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_q[tail_q] <= rd_data;
    end
    if (fire) begin
      byp_data_q <= wr_data;
    end
  end

endmodule

// File: tb/tb_sram_array_rd_frontend.sv
// Randomized bench for sram_array_rd_frontend: a macro model drives sram_r_data (garbage
// whenever no read is returning) and a queue-based reference model predicts every response.
module tb_sram_array_rd_frontend;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 256;

  logic              clock;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              sram_r_en;
  logic [ADDR_W-1:0] sram_r_addr;
  logic [DATA_W-1:0] sram_r_data;
  logic              sram_w_en;
  logic [ADDR_W-1:0] sram_w_addr;
  logic [DATA_W-1:0] sram_w_data;

  sram_array_rd_frontend #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sram_r_en   (sram_r_en),
    .sram_r_addr (sram_r_addr),
    .sram_r_data (sram_r_data),
    .sram_w_en   (sram_w_en),
    .sram_w_addr (sram_w_addr),
    .sram_w_data (sram_w_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errs   = 0;

  function automatic logic [DATA_W-1:0] rand256();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] pat(input logic [7:0] b);
    return {32{b}};
  endfunction

  // Macro model: read-old-data on collision, garbage on sram_r_data when no read returns.
  logic [DATA_W-1:0] mac_mem [64];
  logic [DATA_W-1:0] mac_q;
  assign sram_r_data = mac_q;

  always @(posedge clock) begin
    if (sram_r_en) mac_q <= mac_mem[sram_r_addr];
    else           mac_q <= rand256();
    if (sram_w_en) mac_mem[sram_w_addr] <= sram_w_data;
  end

  // Reference model: array contents plus the ordered list of responses not yet consumed.
  logic [DATA_W-1:0] ref_mem [64];
  logic [DATA_W-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check just after, commit model for the next posedge.
  task automatic step(input logic rv, input logic [ADDR_W-1:0] ra, input logic rr,
                      input logic wv, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wd, output logic fired);
    logic              exp_rdy;
    logic              exp_v;
    logic [DATA_W-1:0] rdat;
    @(negedge clock);
    req_valid  = rv;
    req_addr   = ra;
    resp_ready = rr;
    wr_valid   = wv;
    wr_addr    = wa;
    wr_data    = wd;
    #1;
    exp_rdy = (exp_q.size() < 2);
    fired   = rv && exp_rdy;
    exp_v   = (exp_q.size() > 0);
    check_eq("req_ready", {255'd0, req_ready}, {255'd0, exp_rdy});
    check_eq("sram_r_en", {255'd0, sram_r_en}, {255'd0, fired});
    check_eq("sram_r_addr", {250'd0, sram_r_addr}, fired ? {250'd0, ra} : '0);
    check_eq("sram_w", {sram_w_en, sram_w_addr, sram_w_data[DATA_W-8:0]},
             {wv, wa, wd[DATA_W-8:0]});
    check_eq("resp_valid", {255'd0, resp_valid}, {255'd0, exp_v});
    if (exp_v) check_eq("resp_data", resp_data, exp_q[0]);
    if (exp_v && rr) void'(exp_q.pop_front());
    if (fired) begin
      rdat = (wv && wa == ra) ? wd : ref_mem[ra];
      exp_q.push_back(rdat);
    end
    if (wv) ref_mem[wa] = wd;
  endtask

  task automatic idle(input int n, input logic rr);
    logic f;
    for (int i = 0; i < n; i++) step(1'b0, '0, rr, 1'b0, '0, '0, f);
  endtask

  logic f;
  logic got;

  initial begin
    for (int a = 0; a < 64; a++) begin
      mac_mem[a] = pat(8'(a));
      ref_mem[a] = pat(8'(a));
    end
    mac_q      = '0;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    repeat (2) @(negedge clock);
    #1;
    check_eq("rst req_ready", {255'd0, req_ready}, 256'd1);
    check_eq("rst resp_valid", {255'd0, resp_valid}, 256'd0);
    check_eq("rst resp_data", resp_data, '0);
    check_eq("rst sram_r", {249'd0, sram_r_en, sram_r_addr}, '0);
    check_eq("rst sram_w", {sram_w_en, sram_w_addr, sram_w_data[DATA_W-8:0]}, '0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic write then read
    step(1'b0, '0, 1'b1, 1'b1, 6'd5, pat(8'hA5), f);
    idle(2, 1'b1);
    step(1'b1, 6'd5, 1'b1, 1'b0, '0, '0, f);
    idle(2, 1'b1);

    // Streaming with full throughput
    for (int a = 0; a < 64; a++) step(1'b1, 6'(a), 1'b1, 1'b0, '0, '0, f);
    idle(2, 1'b1);

    // Backpressure: two accepted, third stalls until a pop frees credit
    step(1'b1, 6'd1, 1'b0, 1'b0, '0, '0, f);
    step(1'b1, 6'd2, 1'b0, 1'b0, '0, '0, f);
    for (int i = 0; i < 3; i++) step(1'b1, 6'd3, 1'b0, 1'b0, '0, '0, f);
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      step(1'b1, 6'd3, 1'b1, 1'b0, '0, '0, f);
      got = f;
    end
    check_eq("bp read3 accepted", {255'd0, got}, 256'd1);
    idle(4, 1'b1);

    // Collision: write-first in the request cycle, return-cycle write does not leak in
    step(1'b0, '0, 1'b1, 1'b1, 6'd9, pat(8'h11), f);
    step(1'b1, 6'd9, 1'b1, 1'b1, 6'd9, pat(8'h22), f);
    step(1'b0, '0, 1'b1, 1'b1, 6'd9, pat(8'h33), f);
    idle(1, 1'b1);
    step(1'b1, 6'd9, 1'b1, 1'b0, '0, '0, f);
    idle(2, 1'b1);

    // Randomized traffic on a narrow address range to provoke collisions
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 4) != 0, 6'($urandom % 4), $urandom % 2, $urandom % 2,
           6'($urandom % 4), rand256(), f);
    end
    idle(4, 1'b1);

    // Reset mid-operation with a full buffer
    step(1'b1, 6'd1, 1'b0, 1'b0, '0, '0, f);
    step(1'b1, 6'd2, 1'b0, 1'b0, '0, '0, f);
    idle(1, 1'b0);
    @(negedge clock);
    req_valid = 1'b0;
    wr_valid  = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_eq("async rst resp_valid", {255'd0, resp_valid}, 256'd0);
    check_eq("async rst req_ready", {255'd0, req_ready}, 256'd1);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    idle(3, 1'b1);
    step(1'b1, 6'd7, 1'b1, 1'b0, '0, '0, f);
    idle(2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
